l2_loss_sequencer: RTL and testbench



---
 rtl/l2_pkg.sv | 14 +
 rtl/l2_square_pe.sv | 35 +++
 rtl/l2_loss_sequencer.sv | 116 +++++++++++
 tb/tb_l2_loss_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// Shared fixed-point formats and FSM encoding for the L2-loss sequencer.
package l2_pkg;

  localparam int IL = 8;
  localparam int FL = 12;

  typedef logic signed [IL+FL-1:0] fix_t;
  typedef logic signed [IL+FL:0]   diff_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam fix_t FIX_MAX = fix_t'((64'sd1 <<< (IL+FL-1)) - 64'sd1);

endpackage

// File: rtl/l2_square_pe.sv
// One squared-error lane: subtract, square, drop FL fraction bits, register with valid.
module l2_square_pe #(
  parameter int IL = l2_pkg::IL,
  parameter int FL = l2_pkg::FL
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic signed [IL+FL-1:0]    a,
  input  logic signed [IL+FL-1:0]    b,
  output logic [2*(IL+FL+1)-1:0]     p,
  output logic                       pv
);

  localparam int DW = IL + FL + 1;
  localparam int PW = 2 * DW;

  logic signed [DW-1:0] d;
  logic signed [PW-1:0] sq;

  // One extra bit keeps the difference exact; the square is never negative.
  assign d  = DW'(a) - DW'(b);
  assign sq = PW'(d) * PW'(d);

  always_ff @(posedge clk) begin
    if (reset) begin
      p  <= '0;
      pv <= 1'b0;
    end else begin
      pv <= en;
      if (en) p <= sq >>> FL;
    end
  end

endmodule

// File: rtl/l2_loss_sequencer.sv
// Sequential L2-loss engine: one shared squarer, element per cycle, saturated Q(IL.FL) result.
module l2_loss_sequencer #(
  parameter int IL    = l2_pkg::IL,
  parameter int FL    = l2_pkg::FL,
  parameter int size  = 16,
  parameter int width = $clog2(size),
  parameter int CW    = $clog2(size + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CW-1:0]           num,
  input  logic signed [IL+FL-1:0] yHat [size],
  input  logic signed [IL+FL-1:0] y    [size],
  output logic                    busy,
  output logic                    done,
  output logic signed [IL+FL-1:0] sum,
  output logic                    sat
);

  import l2_pkg::*;

  localparam int W  = IL + FL;
  localparam int PW = 2 * (W + 1);
  localparam int AW = 2 * W + 2 + width;
  localparam logic [AW-1:0] satLimit = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};

  state_t              state;
  logic signed [W-1:0] yHatR [size];
  logic signed [W-1:0] yR    [size];
  logic [CW-1:0]       nCount;
  logic [CW-1:0]       nClamp;
  logic [width-1:0]    idx;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       accNext;
  logic [PW-1:0]       p;
  logic                pv;

  assign nClamp  = (num > CW'(size)) ? CW'(size) : num;
  assign accNext = pv ? acc + AW'(p) : acc;

  l2_square_pe #(.IL(IL), .FL(FL)) pe (
    .clk   (clk),
    .reset (reset),
    .en    (state == RUN),
    .a     (yHatR[idx]),
    .b     (yR[idx]),
    .p     (p),
    .pv    (pv)
  );

  // The result is taken from accNext so the last product, still in flight during DRAIN, is included.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      sat    <= 1'b0;
      nCount <= '0;
      idx    <= '0;
      acc    <= '0;
      for (int k = 0; k < size; k++) begin
        yHatR[k] <= '0;
        yR[k]    <= '0;
      end
    end else begin
      done <= 1'b0;
      acc  <= accNext;
      case (state)
        IDLE: begin
          if (start) begin
            yHatR  <= yHat;
            yR     <= y;
            nCount <= nClamp;
            idx    <= '0;
            acc    <= '0;
            busy   <= 1'b1;
            if (nClamp != '0) begin
              state <= RUN;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              sum   <= '0;
              sat   <= 1'b0;
            end
          end
        end
        RUN: begin
          if (CW'(idx) == nCount - CW'(1)) state <= DRAIN;
          else idx <= idx + width'(1);
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
          if (accNext > satLimit) begin
            sum <= satLimit[W-1:0];
            sat <= 1'b1;
          end else begin
            sum <= accNext[W-1:0];
            sat <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_loss_sequencer.sv
// Self-checking bench for l2_loss_sequencer against a sum-of-squares reference model.
module tb_l2_loss_sequencer;

  localparam int IL   = 8;
  localparam int FL   = 12;
  localparam int SIZE = 16;
  localparam int CW   = 5;
  localparam int W    = IL + FL;
  localparam longint FIXMAX = 524287;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [CW-1:0]       num;
  logic signed [W-1:0] yHat [SIZE];
  logic signed [W-1:0] y    [SIZE];
  logic                busy;
  logic                done;
  logic signed [W-1:0] sum;
  logic                sat;

  logic signed [W-1:0] capYHat [SIZE];
  logic signed [W-1:0] capY    [SIZE];
  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  int     tStart = 0;
  int     expN   = 0;
  longint expSum = 0;
  logic   expSat = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  l2_loss_sequencer #(.IL(IL), .FL(FL), .size(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .num   (num),
    .yHat  (yHat),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .sat   (sat)
  );

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic setAll(input longint yhVal, input longint yVal);
    for (int k = 0; k < SIZE; k++) begin
      yHat[k] = W'(yhVal);
      y[k]    = W'(yVal);
    end
  endtask

  // Pulse start for one cycle and compute the expected loss from the values it captured.
  task automatic applyStimulus(input int numVal);
    longint total;
    longint d;
    @(negedge clk);
    num    = CW'(numVal);
    start  = 1'b1;
    tStart = cyc;
    capYHat = yHat;
    capY    = y;
    expN  = (numVal > SIZE) ? SIZE : numVal;
    total = 0;
    for (int k = 0; k < expN; k++) begin
      d = longint'(capYHat[k]) - longint'(capY[k]);
      total += (d * d) / 4096;
    end
    expSat = (total > FIXMAX);
    expSum = expSat ? FIXMAX : total;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc - tStart;
        break;
      end
    end
  endtask

  task automatic runCheck(input string tag, input int numVal);
    int lat;
    int expLat;
    applyStimulus(numVal);
    expLat = (expN == 0) ? 1 : expN + 2;
    waitDone(lat);
    checkOutput({tag, ".latency"}, longint'(lat), longint'(expLat));
    checkOutput({tag, ".sum"}, longint'(sum), expSum);
    checkOutput({tag, ".sat"}, longint'(sat), longint'(expSat));
    @(negedge clk);
    checkOutput({tag, ".donePulse"}, longint'(done), 0);
    checkOutput({tag, ".idleBusy"}, longint'(busy), 0);
  endtask

  initial begin
    int lat;
    int extra;
    reset = 1'b1;
    start = 1'b0;
    num   = '0;
    setAll(0, 0);
    repeat (3) @(negedge clk);
    checkOutput("reset.busy", longint'(busy), 0);
    checkOutput("reset.done", longint'(done), 0);
    checkOutput("reset.sum", longint'(sum), 0);
    checkOutput("reset.sat", longint'(sat), 0);
    reset = 1'b0;

    setAll(0, 0);
    yHat[0] = W'(4096);
    yHat[1] = W'(8192);
    runCheck("basic", 2);
    checkOutput("basic.const", longint'(sum), 20480);

    setAll(0, 0);
    yHat[0] = W'(-2048);
    y[0]    = W'(2048);
    runCheck("sign", 1);
    checkOutput("sign.const", longint'(sum), 4096);

    setAll(1, 0);
    runCheck("truncLsb", 16);
    checkOutput("truncLsb.const", longint'(sum), 0);

    setAll(0, 0);
    for (int k = 0; k < 4; k++) yHat[k] = W'(409600);
    runCheck("saturate", 4);
    checkOutput("saturate.const", longint'(sum), FIXMAX);
    checkOutput("saturate.flag", longint'(sat), 1);

    setAll(0, 0);
    yHat[0] = W'(4096);
    runCheck("satClear", 1);
    checkOutput("satClear.flag", longint'(sat), 0);

    runCheck("numZero", 0);

    setAll(4096, 0);
    runCheck("fullSize", 16);
    checkOutput("fullSize.const", longint'(sum), 65536);

    setAll(2048, -2048);
    runCheck("clampNum", 20);

    // Start pulses during RUN and DONE must be dropped, and RUN works on captured vectors.
    setAll(0, 0);
    for (int k = 0; k < SIZE; k++) yHat[k] = W'(2048 * (k + 1));
    applyStimulus(4);
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < SIZE; k++) begin
      yHat[k] = W'($urandom);
      y[k]    = W'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    waitDone(lat);
    checkOutput("handshake.latency", longint'(lat), 6);
    checkOutput("handshake.sum", longint'(sum), expSum);
    checkOutput("handshake.const", longint'(sum), 30720);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("handshake.donePulse", longint'(done), 0);
    checkOutput("handshake.ignoredInDone", longint'(busy), 0);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checkOutput("handshake.noSecondDone", longint'(extra), 0);

    setAll(0, 0);
    for (int k = 0; k < SIZE; k++) yHat[k] = W'(1024 * (k + 1));
    applyStimulus(8);
    while (cyc < tStart + 3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort.busy", longint'(busy), 0);
    checkOutput("abort.done", longint'(done), 0);
    checkOutput("abort.sum", longint'(sum), 0);
    checkOutput("abort.sat", longint'(sat), 0);
    reset = 1'b0;
    runCheck("afterAbort", 8);

    for (int r = 0; r < 24; r++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      for (int k = 0; k < SIZE; k++) begin
        if (mode == 0) begin
          yHat[k] = W'(int'($urandom_range(0, 65535)) - 32768);
          y[k]    = W'(int'($urandom_range(0, 65535)) - 32768);
        end else if (mode == 1) begin
          yHat[k] = W'($urandom);
          y[k]    = W'($urandom);
        end else begin
          yHat[k] = W'(int'($urandom_range(0, 262143)) - 131072);
          y[k]    = W'(int'(yHat[k]) + int'($urandom_range(0, 8191)) - 4096);
        end
      end
      runCheck($sformatf("random%0d", r), int'($urandom_range(0, 20)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
